// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 keystream/decrypt engine.
package rc4_pkg;

    localparam int unsigned BYTE_W = 8;

    localparam logic [BYTE_W-1:0] CHAR_LO = 8'h61;
    localparam logic [BYTE_W-1:0] CHAR_HI = 8'h7A;
    localparam logic [BYTE_W-1:0] CHAR_SP = 8'h20;

    // Encoding order is visible on stateTap: Idle=0 ... Done=10.
    typedef enum logic [3:0] {
        Idle,
        RdSi,
        LtSi,
        RdSj,
        LtSj,
        WrSi,
        WrSj,
        RdF,
        LtF,
        WrA,
        Done
    } rc4State_t;

endpackage

// File: rtl/rc4_char_checker.sv
// Flags whether a plaintext byte is a lowercase letter or a space.
module rc4_char_checker
    import rc4_pkg::*;
#(
    parameter bit CHECK_EN = 1'b1
) (
    input  logic [BYTE_W-1:0] charByte,
    output logic              charOk
);

    if (CHECK_EN) begin : gCheck
        assign charOk = ((charByte >= CHAR_LO) && (charByte <= CHAR_HI)) || (charByte == CHAR_SP);
    end else begin : gNoCheck
        logic unusedByte;
        assign unusedByte = ^charByte;
        assign charOk     = 1'b1;
    end

endmodule

// File: rtl/rc4_prga_stream.sv
// RC4 PRGA over a single-port S RAM: one keystream byte per 9 cycles, XORed with ciphertext ROM.
module rc4_prga_stream
    import rc4_pkg::*;
#(
    parameter int unsigned RAM_WIDTH          = 8,
    parameter int unsigned RAM_LENGTH         = 8,
    parameter int unsigned MESSAGE_LENGTH     = 32,
    parameter int unsigned MESSAGE_LOG_LENGTH = 5,
    parameter int unsigned DROP_N             = 0,
    parameter int unsigned CHECK_EN           = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [MESSAGE_LOG_LENGTH:0]   msgLen,
    output logic [RAM_LENGTH-1:0]         sAddr,
    output logic [RAM_WIDTH-1:0]          sIn,
    output logic                          sWren,
    input  logic [RAM_WIDTH-1:0]          sOut,
    output logic [MESSAGE_LOG_LENGTH-1:0] kAddr,
    input  logic [RAM_WIDTH-1:0]          kOut,
    output logic [MESSAGE_LOG_LENGTH-1:0] aAddr,
    output logic [RAM_WIDTH-1:0]          aIn,
    output logic                          aWren,
    output logic                          finished,
    output logic                          badChar,
    output logic [BYTE_W-1:0]             iTap,
    output logic [BYTE_W-1:0]             jTap,
    output logic [BYTE_W-1:0]             kTap,
    output logic [BYTE_W-1:0]             stateTap
);

    localparam int unsigned LenW  = MESSAGE_LOG_LENGTH + 1;
    localparam int unsigned DropW = (DROP_N > 0) ? $clog2(DROP_N + 1) : 1;

    rc4State_t                     state;
    logic [RAM_LENGTH-1:0]         i, j;
    logic [MESSAGE_LOG_LENGTH-1:0] k;
    logic [RAM_WIDTH-1:0]          si, sj, f, c;
    logic [DropW-1:0]              dropCnt;
    logic [LenW-1:0]               msgLenQ;

    logic [RAM_WIDTH-1:0] plain;
    logic                 charOk;
    logic                 inDrop;
    logic                 lastByte;

    assign plain = f ^ c;

    rc4_char_checker #(
        .CHECK_EN(CHECK_EN != 0)
    ) uChecker (
        .charByte(plain),
        .charOk  (charOk)
    );

    if (DROP_N > 0) begin : gDrop
        assign inDrop = dropCnt < DropW'(DROP_N);
    end else begin : gNoDrop
        logic unusedDrop;
        assign unusedDrop = ^dropCnt;
        assign inDrop     = 1'b0;
    end

    // Also stop at the end of the message memories if msgLen exceeds their depth.
    assign lastByte = ({1'b0, k} == msgLenQ - LenW'(1)) ||
                      ({1'b0, k} == LenW'(MESSAGE_LENGTH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= Idle;
            i        <= '0;
            j        <= '0;
            k        <= '0;
            si       <= '0;
            sj       <= '0;
            f        <= '0;
            c        <= '0;
            dropCnt  <= '0;
            msgLenQ  <= '0;
            finished <= 1'b0;
            badChar  <= 1'b0;
        end else begin
            case (state)
                Idle: begin
                    if (start) begin
                        msgLenQ <= msgLen;
                        i       <= RAM_LENGTH'(1);
                        j       <= '0;
                        k       <= '0;
                        dropCnt <= '0;
                        badChar <= 1'b0;
                        state   <= (msgLen == '0) ? Done : RdSi;
                    end
                end
                RdSi: state <= LtSi;
                LtSi: begin
                    si    <= sOut;
                    j     <= j + RAM_LENGTH'(sOut);
                    state <= RdSj;
                end
                RdSj: state <= LtSj;
                LtSj: begin
                    sj    <= sOut;
                    state <= WrSi;
                end
                WrSi: state <= WrSj;
                WrSj: state <= RdF;
                RdF:  state <= LtF;
                LtF: begin
                    f     <= sOut;
                    c     <= kOut;
                    state <= WrA;
                end
                WrA: begin
                    i <= i + RAM_LENGTH'(1);
                    if (inDrop) begin
                        dropCnt <= dropCnt + DropW'(1);
                        state   <= RdSi;
                    end else if (!charOk) begin
                        badChar <= 1'b1;
                        state   <= Done;
                    end else if (lastByte) begin
                        state <= Done;
                    end else begin
                        k     <= k + MESSAGE_LOG_LENGTH'(1);
                        state <= RdSi;
                    end
                end
                Done: begin
                    // finished is shown for at least one cycle before start may release it.
                    finished <= 1'b1;
                    if (finished && !start) begin
                        finished <= 1'b0;
                        state    <= Idle;
                    end
                end
                default: state <= Idle;
            endcase
        end
    end

    always_comb begin
        sAddr = '0;
        sIn   = '0;
        sWren = 1'b0;
        kAddr = '0;
        aAddr = '0;
        aIn   = '0;
        aWren = 1'b0;
        case (state)
            RdSi: sAddr = i;
            RdSj: sAddr = j;
            WrSi: begin
                sAddr = i;
                sIn   = sj;
                sWren = 1'b1;
            end
            WrSj: begin
                sAddr = j;
                sIn   = si;
                sWren = 1'b1;
            end
            RdF: begin
                sAddr = RAM_LENGTH'(si + sj);
                kAddr = k;
            end
            WrA: begin
                aAddr = k;
                aIn   = plain;
                aWren = !inDrop;
            end
            default: ;
        endcase
    end

    assign iTap     = BYTE_W'(i);
    assign jTap     = BYTE_W'(j);
    assign kTap     = BYTE_W'(k);
    assign stateTap = BYTE_W'(state);

endmodule

// File: tb/tb_rc4_prga_stream.sv
// Directed bench: two engines (no drop + text check, drop 1 + no check) on behavioural memories.
module tb_rc4_prga_stream;

    localparam logic [7:0] CodeIdle = 8'd0;
    localparam logic [7:0] CodeWrSi = 8'd5;
    localparam logic [7:0] CodeDone = 8'd10;

    logic clk = 1'b0;
    logic reset;
    logic memInit;
    always #5 clk = ~clk;

    // Engine 0: DROP_N=0, CHECK_EN=1
    logic       start0;
    logic [5:0] msgLen0;
    logic [7:0] sAddr0, sIn0, sOut0, kOut0, aIn0;
    logic [4:0] kAddr0, aAddr0;
    logic       sWren0, aWren0, finished0, badChar0;
    logic [7:0] iTap0, jTap0, kTap0, stateTap0;
    logic [7:0] sMem0[256];
    logic [7:0] rom0[32];
    logic [7:0] aMem0[32];

    // Engine 1: DROP_N=1, CHECK_EN=0
    logic       start1;
    logic [5:0] msgLen1;
    logic [7:0] sAddr1, sIn1, sOut1, kOut1, aIn1;
    logic [4:0] kAddr1, aAddr1;
    logic       sWren1, aWren1, finished1, badChar1;
    logic [7:0] iTap1, jTap1, kTap1, stateTap1;
    logic [7:0] sMem1[256];
    logic [7:0] rom1[32];
    logic [7:0] aMem1[32];

    rc4_prga_stream #(.DROP_N(0), .CHECK_EN(1)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .msgLen(msgLen0),
        .sAddr(sAddr0), .sIn(sIn0), .sWren(sWren0), .sOut(sOut0),
        .kAddr(kAddr0), .kOut(kOut0), .aAddr(aAddr0), .aIn(aIn0), .aWren(aWren0),
        .finished(finished0), .badChar(badChar0),
        .iTap(iTap0), .jTap(jTap0), .kTap(kTap0), .stateTap(stateTap0)
    );

    rc4_prga_stream #(.DROP_N(1), .CHECK_EN(0)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .msgLen(msgLen1),
        .sAddr(sAddr1), .sIn(sIn1), .sWren(sWren1), .sOut(sOut1),
        .kAddr(kAddr1), .kOut(kOut1), .aAddr(aAddr1), .aIn(aIn1), .aWren(aWren1),
        .finished(finished1), .badChar(badChar1),
        .iTap(iTap1), .jTap(jTap1), .kTap(kTap1), .stateTap(stateTap1)
    );

    always_ff @(posedge clk) begin
        sOut0 <= sMem0[sAddr0];
        kOut0 <= rom0[kAddr0];
        sOut1 <= sMem1[sAddr1];
        kOut1 <= rom1[kAddr1];
        if (memInit) begin
            for (int x = 0; x < 256; x++) begin
                sMem0[x] <= 8'(x);
                sMem1[x] <= 8'(x);
            end
            for (int x = 0; x < 32; x++) begin
                aMem0[x] <= 8'h00;
                aMem1[x] <= 8'h00;
            end
        end else begin
            if (sWren0) sMem0[sAddr0] <= sIn0;
            if (aWren0) aMem0[aAddr0] <= aIn0;
            if (sWren1) sMem1[sAddr1] <= sIn1;
            if (aWren1) aMem1[aAddr1] <= aIn1;
        end
    end

    // Observation mux for the engine under test.
    logic       sel;
    logic       selFinished, selAWren, selSWren;
    logic [4:0] selAAddr;
    always_comb begin
        selFinished = sel ? finished1 : finished0;
        selAWren    = sel ? aWren1 : aWren0;
        selSWren    = sel ? sWren1 : sWren0;
        selAAddr    = sel ? aAddr1 : aAddr0;
    end

    int compared = 0;
    int mismatched = 0;
    logic [7:0] ks[8];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulseInit();
        memInit = 1'b1;
        stepCycle();
        memInit = 1'b0;
    endtask

    task automatic runUntilDone(input int budget, output int cycles, output int aCnt,
                                output int sCnt, output logic [7:0] firstA);
        cycles = 0;
        aCnt   = 0;
        sCnt   = 0;
        firstA = 8'hFF;
        while (!selFinished && cycles < budget) begin
            stepCycle();
            cycles++;
            if (selAWren) begin
                if (aCnt == 0) firstA = {3'b000, selAAddr};
                aCnt++;
            end
            if (selSWren) sCnt++;
        end
    endtask

    task automatic idleCount(input int n, output int wrens);
        wrens = 0;
        for (int t = 0; t < n; t++) begin
            stepCycle();
            if (selAWren || selSWren) wrens++;
        end
    endtask

    // Reference RC4 PRGA from the identity permutation.
    task automatic computeKs();
        logic [7:0] s[256];
        logic [7:0] ii, jj, tmp, t;
        for (int x = 0; x < 256; x++) s[x] = 8'(x);
        ii = 8'h00;
        jj = 8'h00;
        for (int n = 0; n < 8; n++) begin
            ii    = ii + 8'h01;
            jj    = jj + s[ii];
            tmp   = s[ii];
            s[ii] = s[jj];
            s[jj] = tmp;
            t     = s[ii] + s[jj];
            ks[n] = s[t];
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, aCnt, sCnt, wrens;
        logic [7:0] firstA;

        sel     = 1'b0;
        reset   = 1'b1;
        memInit = 1'b1;
        start0  = 1'b0;
        start1  = 1'b0;
        msgLen0 = '0;
        msgLen1 = '0;
        for (int x = 0; x < 32; x++) begin
            rom0[x] = 8'h00;
            rom1[x] = 8'h00;
        end
        computeKs();
        stepCycle();
        stepCycle();

        check("rst_finished", finished0, 1'b0);
        check("rst_badChar", badChar0, 1'b0);
        check("rst_state", stateTap0, CodeIdle);
        check("rst_i", iTap0, 8'h00);
        check("rst_wren", {sWren0, aWren0}, 2'b00);
        check("rst_sAddr", sAddr0, 8'h00);
        reset   = 1'b0;
        memInit = 1'b0;
        stepCycle();

        // 1: single byte, i=j=1, f=S[2]=0x02, 0x02^0x63=0x61
        rom0[0] = 8'h63;
        msgLen0 = 6'd1;
        start0  = 1'b1;
        runUntilDone(60, cyc, aCnt, sCnt, firstA);
        check("t1_latency", cyc, 11);
        check("t1_aCnt", aCnt, 1);
        check("t1_sCnt", sCnt, 2);
        check("t1_aAddr", firstA, 8'h00);
        check("t1_plain", aMem0[0], 8'h61);
        check("t1_badChar", badChar0, 1'b0);
        check("t1_j", jTap0, 8'h01);
        check("t1_i", iTap0, 8'h02);
        start0 = 1'b0;
        stepCycle();
        check("t1_release", finished0, 1'b0);
        check("t1_idle", stateTap0, CodeIdle);
        pulseInit();

        // 2: second byte i=2,j=3, swap S[2]/S[3], f=S[5]=0x05
        rom0[1] = 8'h64;
        msgLen0 = 6'd2;
        start0  = 1'b1;
        runUntilDone(60, cyc, aCnt, sCnt, firstA);
        check("t2_latency", cyc, 20);
        check("t2_aCnt", aCnt, 2);
        check("t2_plain0", aMem0[0], 8'h61);
        check("t2_plain1", aMem0[1], 8'h61);
        check("t2_S2", sMem0[2], 8'h03);
        check("t2_S3", sMem0[3], 8'h02);
        check("t2_j", jTap0, 8'h03);
        check("t2_k", kTap0, 8'h01);
        start0 = 1'b0;
        stepCycle();
        pulseInit();

        // 3: one dropped keystream byte, then f=0x05
        sel     = 1'b1;
        rom1[0] = 8'h64;
        msgLen1 = 6'd1;
        start1  = 1'b1;
        runUntilDone(60, cyc, aCnt, sCnt, firstA);
        check("t3_latency", cyc, 20);
        check("t3_aCnt", aCnt, 1);
        check("t3_sCnt", sCnt, 4);
        check("t3_aAddr", firstA, 8'h00);
        check("t3_plain", aMem1[0], 8'h61);
        check("t3_badChar", badChar1, 1'b0);
        start1 = 1'b0;
        stepCycle();
        pulseInit();

        // 4: first plaintext byte 0x02 is invalid -> abort after one byte
        sel     = 1'b0;
        rom0[0] = 8'h00;
        msgLen0 = 6'd32;
        start0  = 1'b1;
        runUntilDone(60, cyc, aCnt, sCnt, firstA);
        check("t4_latency", cyc, 11);
        check("t4_aCnt", aCnt, 1);
        check("t4_plain", aMem0[0], 8'h02);
        check("t4_badChar", badChar0, 1'b1);
        idleCount(20, wrens);
        check("t4_quiet", wrens, 0);
        check("t4_held", {finished0, badChar0}, 2'b11);
        start0 = 1'b0;
        stepCycle();
        pulseInit();

        // 5: reset in WR_SI of byte 5 (cycle 9*5+5 after start)
        for (int n = 0; n < 8; n++) rom0[n] = ks[n] ^ 8'h61;
        msgLen0 = 6'd6;
        start0  = 1'b1;
        for (int t = 0; t < 50; t++) stepCycle();
        check("t5_inWrSi", stateTap0, CodeWrSi);
        check("t5_kBefore", kTap0, 8'h05);
        check("t5_sWrenBefore", sWren0, 1'b1);
        reset = 1'b1;
        #1;
        check("t5_sWrenAsync", sWren0, 1'b0);
        check("t5_taps", {iTap0, jTap0, kTap0, stateTap0}, 32'h0);
        check("t5_finished", finished0, 1'b0);
        start0  = 1'b0;
        memInit = 1'b1;
        stepCycle();
        reset   = 1'b0;
        memInit = 1'b0;
        stepCycle();
        start0 = 1'b1;
        runUntilDone(100, cyc, aCnt, sCnt, firstA);
        check("t5_latency", cyc, 56);
        check("t5_aCnt", aCnt, 6);
        check("t5_aAddr", firstA, 8'h00);
        check("t5_plain0", aMem0[0], 8'h61);
        check("t5_plain5", aMem0[5], 8'h61);
        check("t5_badChar", badChar0, 1'b0);
        start0 = 1'b0;
        stepCycle();
        pulseInit();

        // 6: start held high after finished never restarts
        msgLen0 = 6'd3;
        start0  = 1'b1;
        runUntilDone(60, cyc, aCnt, sCnt, firstA);
        check("t6_latency", cyc, 29);
        idleCount(100, wrens);
        check("t6_quiet", wrens, 0);
        check("t6_stuck", stateTap0, CodeDone);
        check("t6_finished", finished0, 1'b1);
        start0  = 1'b0;
        memInit = 1'b1;
        stepCycle();
        start0  = 1'b1;
        memInit = 1'b0;
        runUntilDone(60, cyc, aCnt, sCnt, firstA);
        check("t6_rerunLatency", cyc, 29);
        check("t6_rerunAddr", firstA, 8'h00);
        check("t6_rerunCnt", aCnt, 3);
        check("t6_rerunPlain", aMem0[2], 8'h61);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
